// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter: FSM states, requester ids, access sizes.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPOND
  } arb_state_t;

  typedef enum logic {
    REQ_IF,
    REQ_D
  } req_sel_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

endpackage

// File: rtl/mem_lane_gen.sv
// Byte-lane decode for one request: byte enables, lane-shifted write data, misalignment flag.
// Purely combinational; no state, no flow control.
module mem_lane_gen
  import mem_arb_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_is_fetch,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misaligned
);

  always_comb begin
    o_be         = 4'b0000;
    o_misaligned = 1'b0;
    o_wdata      = i_wdata << {i_addr_lo, 3'b000};
    if (i_is_fetch) begin
      o_be = 4'b1111;
    end else begin
      case (i_size)
        SIZE_B: o_be = 4'b0001 << i_addr_lo;
        SIZE_H: begin
          o_be         = 4'b0011 << {i_addr_lo[1], 1'b0};
          o_misaligned = i_addr_lo[0];
        end
        SIZE_W: begin
          o_be         = 4'b1111;
          o_misaligned = |i_addr_lo;
        end
        default: o_misaligned = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store onto one memory port, one transaction at a time.
// GNT in IDLE, memory busy for WAIT_CYCLES, one-cycle VALID after; losers simply wait in IDLE.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int WAIT_CYCLES  = 1,
  parameter int STARVE_LIMIT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_valid,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [1:0]        i_d_size,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_gnt,
  output logic              o_d_valid,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_d_err,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [3:0]        o_mem_be,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam logic [3:0] LP_CNT_INIT = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] LP_STARVE   = 4'(STARVE_LIMIT);

  arb_state_t r_state, w_next;
  req_sel_t   r_sel;

  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic              r_err;
  logic              r_first;
  logic [3:0]        r_cnt;
  logic [3:0]        r_starve;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic              w_fetch_sel;
  logic              w_if_win;
  logic              w_d_win;
  logic [1:0]        w_addr_lo;
  logic [ADDR_W-3:0] w_word_addr;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic              w_misaligned;
  logic              w_access;

  // Fetch wins only when data is absent or has already won STARVE_LIMIT times in a row.
  assign w_fetch_sel = i_if_req && (!i_d_req || (r_starve == LP_STARVE));
  assign w_addr_lo   = w_fetch_sel ? i_if_addr[1:0] : i_d_addr[1:0];
  assign w_word_addr = w_fetch_sel ? i_if_addr[ADDR_W-1:2] : i_d_addr[ADDR_W-1:2];

  mem_lane_gen u_lane_gen (
    .i_size       (i_d_size),
    .i_addr_lo    (w_addr_lo),
    .i_is_fetch   (w_fetch_sel),
    .i_wdata      (i_d_wdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_misaligned (w_misaligned)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_if_win = 1'b0;
    w_d_win  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fetch_sel) begin
          w_if_win = 1'b1;
          w_next   = ACCESS;
        end else if (i_d_req) begin
          w_d_win = 1'b1;
          w_next  = w_misaligned ? RESPOND : ACCESS;
        end
      end
      ACCESS:  if (r_cnt == 4'd0) w_next = RESPOND;
      RESPOND: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sel      <= REQ_IF;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_first    <= 1'b0;
      r_cnt      <= '0;
      r_starve   <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (w_if_win || w_d_win) begin
        r_sel   <= w_if_win ? REQ_IF : REQ_D;
        r_addr  <= {w_word_addr, 2'b00};
        r_be    <= w_be;
        r_wdata <= w_wdata;
        r_we    <= w_d_win && i_d_we;
        r_err   <= w_d_win && w_misaligned;
        r_first <= 1'b1;
        r_cnt   <= LP_CNT_INIT;
      end
      // A misaligned access completes without touching memory, so its read data is zero.
      if (w_d_win && w_misaligned) r_d_rdata <= '0;

      if (w_if_win) begin
        r_starve <= '0;
      end else if (w_d_win) begin
        r_starve <= i_if_req ? r_starve + 4'd1 : 4'd0;
      end

      if (r_state == ACCESS) begin
        r_first <= 1'b0;
        if (r_cnt == 4'd0) begin
          if (r_sel == REQ_IF) r_if_rdata <= i_mem_rdata;
          else                 r_d_rdata  <= i_mem_rdata;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

  assign w_access    = (r_state == ACCESS);
  assign o_if_gnt    = w_if_win;
  assign o_d_gnt     = w_d_win;
  assign o_mem_en    = w_access;
  assign o_mem_we    = w_access && r_we && r_first;
  assign o_mem_be    = w_access ? r_be : 4'b0000;
  assign o_mem_addr  = w_access ? r_addr : '0;
  assign o_mem_wdata = w_access ? r_wdata : '0;
  assign o_if_valid  = (r_state == RESPOND) && (r_sel == REQ_IF);
  assign o_d_valid   = (r_state == RESPOND) && (r_sel == REQ_D);
  assign o_d_err     = o_d_valid && r_err;
  assign o_if_rdata  = r_if_rdata;
  assign o_d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: WAIT_CYCLES=1 instance for arbitration/lane checks, WAIT_CYCLES=3 instance for reset abort.
module tb_mem_port_arbiter;

  localparam int W1 = 1;
  localparam int W3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1_n, rst3_n;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [1:0]  d_size;

  logic        if_gnt1, if_valid1, d_gnt1, d_valid1, d_err1, mem_en1, mem_we1;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic [3:0]  mem_be1;
  logic        if_gnt3, if_valid3, d_gnt3, d_valid3, d_err3, mem_en3, mem_we3;
  logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic [3:0]  mem_be3;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h00500093;
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  assign mem_rdata1 = mem_word(mem_addr1);
  assign mem_rdata3 = mem_word(mem_addr3);

  mem_port_arbiter #(.WAIT_CYCLES(W1), .STARVE_LIMIT(2)) u_dut (
    .i_clk(clk), .i_rst_n(rst1_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt1), .o_if_valid(if_valid1), .o_if_rdata(if_rdata1),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_size(d_size), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_gnt(d_gnt1), .o_d_valid(d_valid1), .o_d_rdata(d_rdata1), .o_d_err(d_err1),
    .o_mem_en(mem_en1), .o_mem_we(mem_we1), .o_mem_be(mem_be1), .o_mem_addr(mem_addr1),
    .o_mem_wdata(mem_wdata1), .i_mem_rdata(mem_rdata1)
  );

  mem_port_arbiter #(.WAIT_CYCLES(W3), .STARVE_LIMIT(2)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst3_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt3), .o_if_valid(if_valid3), .o_if_rdata(if_rdata3),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_size(d_size), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_gnt(d_gnt3), .o_d_valid(d_valid3), .o_d_rdata(d_rdata3), .o_d_err(d_err3),
    .o_mem_en(mem_en3), .o_mem_we(mem_we3), .o_mem_be(mem_be3), .o_mem_addr(mem_addr3),
    .o_mem_wdata(mem_wdata3), .i_mem_rdata(mem_rdata3)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
    int          vcyc;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          n_en;
    int          n_we;
  } exp_t;

  exp_t sb_q[$];
  logic gnt_log[$];
  int   cyc = 0;
  int   n_gnt = 0;
  int   obs_en = 0;
  int   obs_we = 0;
  logic [31:0] obs_addr, obs_wd;
  logic [3:0]  obs_be;

  always @(posedge clk) cyc <= cyc + 1;

  // Model of the 1-wait instance: expectations built from the request seen at grant time.
  always @(negedge clk) begin
    if (rst1_n) begin
      if (if_valid1 || d_valid1) begin
        check("dual_valid", 32'(if_valid1 & d_valid1), 0);
        if (sb_q.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("valid_port", 32'(d_valid1), 32'(e.is_d));
          check("valid_cycle", cyc, e.vcyc);
          check("rdata", e.is_d ? d_rdata1 : if_rdata1, e.rdata);
          check("d_err", 32'(d_err1), 32'(e.err));
          check("en_cycles", obs_en, e.n_en);
          check("we_pulses", obs_we, e.n_we);
          if (e.n_en > 0) begin
            check("mem_addr", obs_addr, e.maddr);
            check("mem_be", 32'(obs_be), 32'(e.be));
          end
          if (e.n_we > 0) check("mem_wdata", obs_wd, e.wd);
        end
      end
      if (mem_en1) begin
        if (obs_en == 0) begin
          obs_addr = mem_addr1;
          obs_be   = mem_be1;
          obs_wd   = mem_wdata1;
        end
        obs_en++;
        if (mem_we1) obs_we++;
      end
      if (if_gnt1 || d_gnt1) begin
        exp_t e;
        int off, nb;
        logic mis;
        check("one_gnt", 32'(if_gnt1 & d_gnt1), 0);
        off = int'(d_addr[1:0]);
        nb  = (d_size == 2'b00) ? 1 : (d_size == 2'b01) ? 2 : (d_size == 2'b10) ? 4 : 0;
        mis = (nb == 0) ? 1'b1 : ((off % nb) != 0);
        e.is_d = d_gnt1;
        if (d_gnt1) begin
          e.maddr = {d_addr[31:2], 2'b00};
          for (int i = 0; i < 4; i++) e.be[i] = (i >= off) && (i < off + nb);
          e.wd    = d_wdata << (8 * off);
          e.err   = mis;
          e.rdata = mis ? 32'h0 : mem_word(e.maddr);
          e.n_en  = mis ? 0 : W1;
          e.n_we  = (!mis && d_we) ? 1 : 0;
          e.vcyc  = cyc + (mis ? 1 : W1 + 1);
        end else begin
          e.maddr = {if_addr[31:2], 2'b00};
          e.be    = 4'b1111;
          e.wd    = 32'h0;
          e.err   = 1'b0;
          e.rdata = mem_word(e.maddr);
          e.n_en  = W1;
          e.n_we  = 0;
          e.vcyc  = cyc + W1 + 1;
        end
        sb_q.push_back(e);
        gnt_log.push_back(d_gnt1);
        n_gnt++;
        obs_en = 0;
        obs_we = 0;
      end
    end
  end

  task automatic wait_grants(input int n, input int budget);
    int start;
    int k;
    start = n_gnt;
    k = 0;
    while ((n_gnt - start) < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    if ((n_gnt - start) < n) check("grant_timeout", n_gnt - start, n);
    #1;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("drain", sb_q.size(), 0);
  endtask

  task automatic d_txn(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    d_req = 1'b1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
    wait_grants(1, 20);
    d_req = 1'b0; d_wdata = 32'hDEAD_BEEF;
    drain(20);
  endtask

  // Single transaction on the 3-wait instance with inline timing checks.
  task automatic t3_run(input logic is_d, input logic [31:0] a, input logic [1:0] sz,
                        input logic [3:0] exp_be, input logic [31:0] exp_rd);
    int g;
    int k;
    @(posedge clk); #1;
    if (is_d) begin
      d_req = 1'b1; d_we = 1'b0; d_size = sz; d_addr = a;
    end else begin
      if_req = 1'b1; if_addr = a;
    end
    @(negedge clk);
    check("r3_gnt", 32'(is_d ? d_gnt3 : if_gnt3), 1);
    g = cyc;
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check("r3_be", 32'(mem_be3), 32'(exp_be));
    k = 0;
    while (!(if_valid3 || d_valid3) && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("r3_latency", cyc - g, W3 + 1);
    check("r3_port", 32'(d_valid3), 32'(is_d));
    check("r3_rdata", is_d ? d_rdata3 : if_rdata3, exp_rd);
    check("r3_err", 32'(d_err3), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst1_n = 1'b0; rst3_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {if_gnt1, if_valid1, d_gnt1, d_valid1, d_err1, mem_en1, mem_we1, mem_be1}, 0);
    check("rst_rdata", if_rdata1 | d_rdata1 | mem_addr1 | mem_wdata1, 0);
    rst1_n = 1'b1;

    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h100;
    wait_grants(1, 20);
    if_req = 1'b0;
    drain(20);

    d_txn(1'b1, 2'b00, 32'h203, 32'h0000_00AB);
    d_txn(1'b0, 2'b10, 32'h102, 32'h0);
    d_txn(1'b0, 2'b01, 32'h00E, 32'h0);
    d_txn(1'b1, 2'b01, 32'h006, 32'h0000_1234);
    d_txn(1'b1, 2'b10, 32'h010, 32'hCAFE_F00D);
    d_txn(1'b0, 2'b00, 32'h101, 32'h0);
    d_txn(1'b0, 2'b11, 32'h020, 32'h0);
    d_txn(1'b0, 2'b01, 32'h103, 32'h0);

    gnt_log.delete();
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h040;
    wait_grants(3, 40);
    if_req = 1'b0; d_req = 1'b0;
    drain(20);
    check("order_len", gnt_log.size(), 3);
    if (gnt_log.size() >= 3) begin
      check("order0_D", 32'(gnt_log[0]), 1);
      check("order1_D", 32'(gnt_log[1]), 1);
      check("order2_IF", 32'(gnt_log[2]), 0);
    end

    @(negedge clk);
    rst1_n = 1'b0;
    rst3_n = 1'b1;

    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h080;
    @(negedge clk);
    check("r3_gnt_a", 32'(if_gnt3), 1);
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    check("r3_en_c1", 32'(mem_en3), 1);
    @(posedge clk); #2;
    check("r3_en_c2", 32'(mem_en3), 1);
    rst3_n = 1'b0;
    #1;
    check("r3_en_drop", {mem_en3, mem_we3, mem_be3, if_valid3, d_valid3}, 0);
    check("r3_addr_drop", mem_addr3, 0);
    repeat (6) begin
      @(negedge clk);
      check("r3_no_valid", 32'(if_valid3 | d_valid3), 0);
    end
    rst3_n = 1'b1;
    t3_run(1'b0, 32'h080, 2'b10, 4'b1111, mem_word(32'h080));
    t3_run(1'b1, 32'h00E, 2'b01, 4'b1100, mem_word(32'h00C));

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
